arr_feeder4: RTL and testbench

//  Upstream feeder for the 4x4 weight-stationary systolic array (Arr4x4).
//  - Loads N weight vectors into the array's w-chain, then drives the array's hold input.
//  - Converts unskewed activation vectors into the diagonal (skewed) a1..aN streams the array expects.
//  - Appends zero-flush cycles and signals completion.

---
 rtl/arr_feeder4.sv | 140 ++++++++++++++
 tb/tb_arr_feeder4.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arr_feeder4.sv
// Upstream feeder for a weight-stationary systolic array: loads the weight chain,
// skews activation vectors diagonally, appends zero-flush cycles and pulses done.
module arr_feeder4 #(
  parameter int N         = 4,
  parameter int DW        = 8,
  parameter int FLUSH_CYC = 2*N-1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            w_valid,
  output logic            w_ready,
  input  logic [N*DW-1:0] w_data,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic            a_last,
  input  logic [N*DW-1:0] a_data,
  output logic [N*DW-1:0] w_out,
  output logic [N*DW-1:0] a_out,
  output logic [N-1:0]    sk_valid,
  output logic            hold,
  output logic            busy,
  output logic            done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD_W = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_FLUSH  = 2'd3;

  localparam int WCW = ($clog2(N) > 0) ? $clog2(N) : 1;
  localparam int FCW = ($clog2(FLUSH_CYC) > 0) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [WCW-1:0] WCNT_LAST = WCW'(N-1);
  localparam logic [FCW-1:0] FCNT_LAST = FCW'(FLUSH_CYC-1);

  logic [1:0]      state_q, state_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic [FCW-1:0]  fcnt_q, fcnt_d;
  logic [N*DW-1:0] w_out_q;
  logic            hold_q;
  logic            busy_q;
  logic            done_q;
  logic            w_acc;
  logic            a_acc;

  assign w_ready = (state_q == S_LOAD_W);
  assign a_ready = (state_q == S_STREAM);
  assign w_acc   = w_valid & w_ready;
  assign a_acc   = a_valid & a_ready;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_W;
          wcnt_d  = '0;
        end
      end
      S_LOAD_W: begin
        if (w_acc) begin
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == WCNT_LAST) begin
            state_d = S_STREAM;
            wcnt_d  = '0;
          end
        end
      end
      S_STREAM: begin
        if (a_acc && a_last) begin
          state_d = S_FLUSH;
          fcnt_d  = '0;
        end
      end
      default: begin
        fcnt_d = fcnt_q + 1'b1;
        if (fcnt_q == FCNT_LAST) begin
          state_d = S_IDLE;
          fcnt_d  = '0;
        end
      end
    endcase
  end

  // done/busy are registered from next-state so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      fcnt_q  <= '0;
      w_out_q <= '0;
      hold_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      fcnt_q  <= fcnt_d;
      w_out_q <= w_acc ? w_data : '0;
      hold_q  <= ~w_acc;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_FLUSH) && (fcnt_d == FCNT_LAST);
    end
  end

  assign w_out = w_out_q;
  assign hold  = hold_q;
  assign busy  = busy_q;
  assign done  = done_q;

  // Lane gi has gi+1 registers, so an element accepted at t shows at t+1+gi
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [DW-1:0] pipe_q [0:gi];
      logic          vld_q  [0:gi];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 0; j <= gi; j++) begin
            pipe_q[j] <= '0;
            vld_q[j]  <= 1'b0;
          end
        end else begin
          pipe_q[0] <= a_acc ? a_data[gi*DW +: DW] : '0;
          vld_q[0]  <= a_acc;
          for (int j = 1; j <= gi; j++) begin
            pipe_q[j] <= pipe_q[j-1];
            vld_q[j]  <= vld_q[j-1];
          end
        end
      end

      assign a_out[gi*DW +: DW] = pipe_q[gi];
      assign sk_valid[gi]       = vld_q[gi];
    end
  endgenerate

endmodule

// File: tb/tb_arr_feeder4.sv
// Scoreboard bench for arr_feeder4: expectations are queued at handshake time
// and retired by a negedge monitor as the skewed lanes, weights and done appear.
module tb_arr_feeder4;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int FC = 2*N-1;

  logic            clk = 1'b0;
  logic            rst, start, w_valid, a_valid, a_last;
  logic            w_ready, a_ready, hold, busy, done;
  logic [N*DW-1:0] w_data, a_data, w_out, a_out;
  logic [N-1:0]    sk_valid;

  arr_feeder4 #(.N(N), .DW(DW), .FLUSH_CYC(FC)) dut (
    .clk(clk), .rst(rst), .start(start),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_last(a_last), .a_data(a_data),
    .w_out(w_out), .a_out(a_out), .sk_valid(sk_valid),
    .hold(hold), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } exp_t;

  exp_t wq[$];
  exp_t aq[N][$];
  int   dq[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Monitor: retire expectations as outputs appear
  always @(negedge clk) begin
    exp_t e;
    int   d;
    if (!hold) begin
      if (wq.size() == 0) check("w_unexpected", 1, 0);
      else begin
        e = wq.pop_front();
        check("w_cycle", cyc, e.cyc);
        check("w_data", w_out, e.val);
      end
    end else begin
      check("w_idle_zero", w_out, 0);
      if (wq.size() > 0 && wq[0].cyc <= cyc) begin
        e = wq.pop_front();
        check("w_missing", cyc, e.cyc + 1000);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (sk_valid[i]) begin
        if (aq[i].size() == 0) check("a_unexpected", i, 99);
        else begin
          e = aq[i].pop_front();
          check("a_cycle", cyc, e.cyc);
          check("a_data", a_out[i*DW +: DW], e.val);
        end
      end else begin
        check("a_bubble_zero", a_out[i*DW +: DW], 0);
        if (aq[i].size() > 0 && aq[i][0].cyc <= cyc) begin
          e = aq[i].pop_front();
          check("a_missing", cyc, e.cyc + 1000);
        end
      end
    end
    if (done) begin
      if (dq.size() == 0) check("done_unexpected", 1, 0);
      else begin
        d = dq.pop_front();
        check("done_cycle", cyc, d);
      end
    end else if (dq.size() > 0 && dq[0] <= cyc) begin
      d = dq.pop_front();
      check("done_missing", cyc, d + 1000);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    wq.delete();
    for (int i = 0; i < N; i++) aq[i].delete();
    dq.delete();
    rst = 1'b0;
    @(negedge clk);
    check("rst_a_out", a_out, 0);
    check("rst_sk_valid", sk_valid, 0);
    check("rst_w_out", w_out, 0);
    check("rst_hold", hold, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_readies", {w_ready, a_ready}, 0);
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d);
    exp_t e;
    bit   acc;
    w_valid = 1'b1;
    w_data  = d;
    for (int g = 0; g < 20; g++) begin
      acc = w_ready;
      if (acc) begin
        e.cyc = cyc + 1;
        e.val = d;
        wq.push_back(e);
      end
      tick();
      if (acc) break;
      if (g == 19) check("w_timeout", 1, 0);
    end
    w_valid = 1'b0;
  endtask

  task automatic send_a(input logic [31:0] d, input bit last);
    exp_t e;
    bit   acc;
    a_valid = 1'b1;
    a_data  = d;
    a_last  = last;
    for (int g = 0; g < 20; g++) begin
      acc = a_ready;
      if (acc) begin
        for (int i = 0; i < N; i++) begin
          e.cyc = cyc + 1 + i;
          e.val = {24'd0, d[i*DW +: DW]};
          aq[i].push_back(e);
        end
        if (last) dq.push_back(cyc + FC);
      end
      tick();
      if (acc) break;
      if (g == 19) check("a_timeout", 1, 0);
    end
    a_valid = 1'b0;
    a_last  = 1'b0;
  endtask

  task automatic load4();
    send_w({8'd4, 8'd3, 8'd2, 8'd1});
    send_w({8'd8, 8'd7, 8'd6, 8'd5});
    send_w({8'd4, 8'd3, 8'd2, 8'd1});
    send_w({8'd8, 8'd7, 8'd6, 8'd5});
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy && g < 100) begin
      tick();
      g++;
    end
    check("idle_timeout", busy, 0);
    check("w_queue_empty", wq.size(), 0);
    check("done_queue_empty", dq.size(), 0);
    for (int i = 0; i < N; i++) check("a_queue_empty", aq[i].size(), 0);
    tick();
  endtask

  initial begin
    logic [7:0] k8;
    rst = 1'b1; start = 1'b0; w_valid = 1'b0; a_valid = 1'b0; a_last = 1'b0;
    w_data = '0; a_data = '0;
    tick();
    do_reset();

    // Job 1: back-to-back weights, 8 uniform vectors k=8..1
    pulse_start();
    check("busy_after_start", busy, 1);
    check("a_ready_in_load", a_ready, 0);
    load4();
    for (int k = 8; k >= 1; k--) begin
      k8 = 8'(k);
      send_a({k8, k8, k8, k8}, k == 1);
    end
    wait_idle();
    $display("job1 uniform stream checks=%0d failures=%0d", n_checks, n_fail);

    // Job 2: two-cycle weight gap, then a mid-stream bubble
    pulse_start();
    send_w(32'h11223344);
    send_w(32'h55667788);
    for (int g = 0; g < 2; g++) begin
      check("gap_w_ready", w_ready, 1);
      tick();
    end
    send_w(32'h99AABBCC);
    send_w(32'hDDEEFF01);
    send_a(32'h0A0B0C0D, 1'b0);
    tick();
    send_a(32'h1A1B1C1D, 1'b0);
    send_a(32'h2A2B2C2D, 1'b1);
    wait_idle();
    $display("job2 gap and bubble checks=%0d failures=%0d", n_checks, n_fail);

    // Job 3: reset during STREAM, then a full job with random data
    pulse_start();
    load4();
    send_a(32'hDEADBEEF, 1'b0);
    send_a(32'hCAFEF00D, 1'b0);
    do_reset();
    pulse_start();
    load4();
    for (int v = 0; v < 3; v++) send_a($urandom, v == 2);
    wait_idle();
    $display("job3 reset abort checks=%0d failures=%0d", n_checks, n_fail);

    // Job 4: single-vector job with start pulsed during FLUSH
    pulse_start();
    load4();
    send_a(32'h5F6E7D8C, 1'b1);
    tick();
    tick();
    pulse_start();
    wait_idle();
    for (int g = 0; g < 3; g++) begin
      check("start_ignored_busy", busy, 0);
      check("start_ignored_w_ready", w_ready, 0);
      tick();
    end
    $display("job4 single vector checks=%0d failures=%0d", n_checks, n_fail);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
